// File: rtl/ch0re_alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ch0re_types (package)
//  Purpose  : Shared types for the execute-stage ALU issue block: ALU op
//             encoding, request/response structs and small helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package ch0re_types;

    localparam int C_XLEN       = 64;
    localparam int C_REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } alu_op_e;

    typedef struct packed {
        alu_op_e                 op;
        logic                    word;
        logic                    is_branch;
        logic [C_XLEN-1:0]       s1;
        logic [C_XLEN-1:0]       s2;
        logic [C_XLEN-1:0]       pc;
        logic [C_XLEN-1:0]       imm;
        logic [C_REG_ADDR_W-1:0] rd;
    } ch0re_ex_req_t;

    typedef struct packed {
        logic [C_XLEN-1:0]       res;
        logic [C_REG_ADDR_W-1:0] rd;
        logic                    br_taken;
        logic [C_XLEN-1:0]       br_target;
    } ch0re_ex_rsp_t;

    // Sign-extend a 32-bit word result to the full datapath width.
    function automatic logic [C_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(C_XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ch0re_alu_issue_br_eval.sv
`default_nettype none
// ============================================================================
//  Module   : ch0re_br_eval
//  Purpose  : Combinational branch condition evaluation from ALU flags.
//             Corrects the signed less-than flag when operand signs differ,
//             since the ALU's subtract-based flag is wrong on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module ch0re_br_eval
    import ch0re_types::*;
(
    input  alu_op_e i_op,
    input  logic    i_zero,
    input  logic    i_less,
    input  logic    i_s1_sign,
    input  logic    i_s2_sign,
    output logic    o_taken
);

    logic w_less;

    // Signed-compare fix-up followed by condition selection.
    always_comb begin
        w_less  = i_less;
        o_taken = 1'b0;
        if (((i_op == ALU_LT) || (i_op == ALU_GE)) && (i_s1_sign != i_s2_sign)) begin
            w_less = i_s1_sign;
        end
        case (i_op)
            ALU_EQ:  o_taken = i_zero;
            ALU_NE:  o_taken = !i_zero;
            ALU_LT:  o_taken = w_less;
            ALU_LTU: o_taken = w_less;
            ALU_GE:  o_taken = !w_less;
            ALU_GEU: o_taken = !w_less;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ch0re_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : ch0re_alu_issue
//  Purpose  : Execute-stage front end. S0 registers an accepted request and
//             drives the external combinational ALU; S1 registers the
//             formed writeback / branch result toward downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module ch0re_alu_issue
    import ch0re_types::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  alu_op_e               i_op,
    input  logic                  i_word,
    input  logic                  i_is_branch,
    input  logic [XLEN-1:0]       i_s1,
    input  logic [XLEN-1:0]       i_s2,
    input  logic [XLEN-1:0]       i_pc,
    input  logic [XLEN-1:0]       i_imm,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output alu_op_e               o_alu_op,
    output logic [XLEN-1:0]       o_alu_s1,
    output logic [XLEN-1:0]       o_alu_s2,
    input  logic [XLEN-1:0]       i_alu_res,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_less,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_res,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_br_taken,
    output logic [XLEN-1:0]       o_br_target
);

    logic          s0_valid_q, s0_valid_d;
    ch0re_ex_req_t s0_req_q,   s0_req_d;
    logic          s1_valid_q, s1_valid_d;
    ch0re_ex_rsp_t s1_rsp_q,   s1_rsp_d;

    logic          w_s0_adv;
    logic          w_accept;
    logic          w_taken;
    ch0re_ex_req_t w_req;
    ch0re_ex_rsp_t w_rsp;

    // S0 may move into S1 whenever S1 is empty or being drained this cycle.
    assign w_s0_adv = !s1_valid_q || i_ready;
    assign o_ready  = !s0_valid_q || w_s0_adv;
    assign w_accept = i_valid && o_ready;

    // Pack the incoming request for the S0 register.
    always_comb begin
        w_req           = '0;
        w_req.op        = i_op;
        w_req.word      = i_word;
        w_req.is_branch = i_is_branch;
        w_req.s1        = i_s1;
        w_req.s2        = i_s2;
        w_req.pc        = i_pc;
        w_req.imm       = i_imm;
        w_req.rd        = i_rd;
    end

    // Drive the ALU from S0, narrowing operands for 32-bit shifts.
    always_comb begin
        o_alu_op = s0_req_q.op;
        o_alu_s1 = s0_req_q.s1;
        o_alu_s2 = s0_req_q.s2;
        if (s0_req_q.word && is_shift(s0_req_q.op)) begin
            o_alu_s2 = {{(XLEN-5){1'b0}}, s0_req_q.s2[4:0]};
            if (s0_req_q.op == ALU_SRL) begin
                o_alu_s1 = {{(XLEN-32){1'b0}}, s0_req_q.s1[31:0]};
            end else if (s0_req_q.op == ALU_SRA) begin
                o_alu_s1 = sext32(s0_req_q.s1[31:0]);
            end
        end
    end

    ch0re_br_eval u_br_eval (
        .i_op      (s0_req_q.op),
        .i_zero    (i_alu_zero),
        .i_less    (i_alu_less),
        .i_s1_sign (s0_req_q.s1[XLEN-1]),
        .i_s2_sign (s0_req_q.s2[XLEN-1]),
        .o_taken   (w_taken)
    );

    // Form the writeback / branch response from the ALU result.
    always_comb begin
        w_rsp           = '0;
        w_rsp.rd        = s0_req_q.rd;
        if (s0_req_q.is_branch) begin
            w_rsp.br_taken  = w_taken;
            w_rsp.br_target = s0_req_q.pc + s0_req_q.imm;
        end else if (s0_req_q.word) begin
            w_rsp.res = sext32(i_alu_res[31:0]);
        end else begin
            w_rsp.res = i_alu_res;
        end
    end

    // Pipeline next-state: flush beats accept/advance; S1 holds under stall.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_req_d   = s0_req_q;
        s1_valid_d = s1_valid_q;
        s1_rsp_d   = s1_rsp_q;
        if (i_flush) begin
            s0_valid_d = 1'b0;
            s1_valid_d = 1'b0;
        end else begin
            if (w_s0_adv) begin
                s1_valid_d = s0_valid_q;
                if (s0_valid_q) begin
                    s1_rsp_d = w_rsp;
                end
                s0_valid_d = 1'b0;
            end
            if (w_accept) begin
                s0_valid_d = 1'b1;
                s0_req_d   = w_req;
            end
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s0_valid_q <= 1'b0;
            s0_req_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_rsp_q   <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_req_q   <= s0_req_d;
            s1_valid_q <= s1_valid_d;
            s1_rsp_q   <= s1_rsp_d;
        end
    end

    assign o_valid     = s1_valid_q;
    assign o_res       = s1_rsp_q.res;
    assign o_rd        = s1_rsp_q.rd;
    assign o_br_taken  = s1_rsp_q.br_taken;
    assign o_br_target = s1_rsp_q.br_target;

endmodule
`default_nettype wire
